// File: rtl/picorv32_mem_responder_if.sv
// picorv32_mem_responder_if
// Native PicoRV32 memory bus between an initiator (master) and the memory
// responder (slave).
//   mem_valid  master->slave  request pending
//   mem_instr  master->slave  request is an instruction fetch
//   mem_addr   master->slave  byte address (bits [1:0] ignored by the slave)
//   mem_wdata  master->slave  write data
//   mem_wstrb  master->slave  byte write strobes, 0 = read
//   mem_ready  slave->master  one-cycle transfer-complete pulse
//   mem_rdata  slave->master  read data, valid while mem_ready is high
interface picorv32_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder
// Word-organised RAM that answers PicoRV32 native bus requests after a
// programmable wait time, with sticky error flags and transfer counters.
//   clk        single clock, rising edge
//   resetn     asynchronous active-low reset
//   bus        slave side of the memory bus
//   stall      holds the wait counter while high
//   range_err  sticky: a transfer addressed a word >= MEM_WORDS
//   proto_err  sticky: mem_valid dropped while waiting
//   cnt_fetch  completed instruction fetches (saturating)
//   cnt_rd     completed data reads (saturating)
//   cnt_wr     completed writes (saturating)
//
// state  | meaning
// IDLE   | no request held; samples mem_valid
// WAIT   | request latched; wait counter running (held by stall)
// RESP   | mem_ready high for this single cycle; writes commit at its end
module picorv32_mem_responder #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  picorv32_mem_responder_if.slave   bus,
  input  logic                      stall,
  output logic                      range_err,
  output logic                      proto_err,
  output logic [15:0]               cnt_fetch,
  output logic [15:0]               cnt_rd,
  output logic [15:0]               cnt_wr
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  wait_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        range_err_q;
  logic        proto_err_q;
  logic [15:0] cnt_fetch_q;
  logic [15:0] cnt_rd_q;
  logic [15:0] cnt_wr_q;

  // Backing store is deliberately not reset so software-visible contents
  // survive a controller reset.
  logic [31:0] ram_q [MEM_WORDS];

  logic        in_range_new;
  logic        in_range_lat;
  logic [31:0] rd_new_d;
  logic [31:0] rd_lat_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Read data is looked up on the edge that enters RESP so mem_rdata is a
  // plain register during the ready pulse. The zero-latency path enters RESP
  // straight from IDLE, before the request fields are latched, so it reads
  // through the live bus address instead.
  always_comb begin
    in_range_new = bus.mem_addr[31:2] < 30'(MEM_WORDS);
    in_range_lat = word_q < 30'(MEM_WORDS);
    rd_new_d     = 32'd0;
    rd_lat_d     = 32'd0;
    if (bus.mem_wstrb == 4'd0 && in_range_new)
      rd_new_d = ram_q[bus.mem_addr[IDX_W+1:2]];
    if (wstrb_q == 4'd0 && in_range_lat)
      rd_lat_d = ram_q[word_q[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      wait_q      <= 4'd0;
      word_q      <= 30'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      instr_q     <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'd0;
      range_err_q <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_fetch_q <= 16'd0;
      cnt_rd_q    <= 16'd0;
      cnt_wr_q    <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.mem_valid) begin
            word_q  <= bus.mem_addr[31:2];
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            instr_q <= bus.mem_instr;
            wait_q  <= 4'(LATENCY);
            if (LATENCY == 0 && !stall) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              rdata_q <= rd_new_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.mem_valid) begin
            state_q     <= S_IDLE;
            proto_err_q <= 1'b1;
          end else if (!stall) begin
            if (wait_q == 4'd0) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              rdata_q <= rd_lat_d;
            end else begin
              wait_q <= wait_q - 4'd1;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= 32'd0;
          if (!in_range_lat)
            range_err_q <= 1'b1;
          if (wstrb_q != 4'd0)
            cnt_wr_q <= sat_inc(cnt_wr_q);
          else if (instr_q)
            cnt_fetch_q <= sat_inc(cnt_fetch_q);
          else
            cnt_rd_q <= sat_inc(cnt_rd_q);
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= 32'd0;
        end
      endcase
    end
  end

  // Write commits on the edge that leaves RESP; out-of-range writes drop.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && wstrb_q != 4'd0 && in_range_lat) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b])
          ram_q[word_q[IDX_W-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign range_err     = range_err_q;
  assign proto_err     = proto_err_q;
  assign cnt_fetch     = cnt_fetch_q;
  assign cnt_rd        = cnt_rd_q;
  assign cnt_wr        = cnt_wr_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// tb_picorv32_mem_responder
// Transaction-level bench: each request's ready cycle, read data, RAM image,
// counters and error flags are predicted from the bus rules and compared
// against the responder.
module tb_picorv32_mem_responder;
  localparam int MW  = 256;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        range_err;
  logic        proto_err;
  logic [15:0] cnt_fetch;
  logic [15:0] cnt_rd;
  logic [15:0] cnt_wr;

  picorv32_mem_responder_if bus_if ();

  picorv32_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if),
    .stall     (stall),
    .range_err (range_err),
    .proto_err (proto_err),
    .cnt_fetch (cnt_fetch),
    .cnt_rd    (cnt_rd),
    .cnt_wr    (cnt_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model
  logic [31:0] ram_m [MW];
  int          m_fetch = 0;
  int          m_rd = 0;
  int          m_wr = 0;
  bit          m_rerr = 0;
  bit          m_perr = 0;
  int          ready_at = -1;
  logic [31:0] rdata_at = 32'd0;
  int          last_e0 = 0;
  int          last_ready_cyc = -1;
  logic [31:0] last_rdata = 32'd0;

  initial for (int i = 0; i < MW; i++) ram_m[i] = 32'd0;

  // per-cycle compare of the handshake outputs
  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = (cyc == ready_at) && resetn;
    check("mem_ready", {31'd0, bus_if.mem_ready}, {31'd0, exp_rdy});
    check("mem_rdata", bus_if.mem_rdata, exp_rdy ? rdata_at : 32'd0);
    if (bus_if.mem_ready === 1'b1) begin
      last_ready_cyc = cyc;
      last_rdata     = bus_if.mem_rdata;
    end
  end

  task automatic check_status();
    check("cnt_fetch", {16'd0, cnt_fetch}, 32'(m_fetch));
    check("cnt_rd",    {16'd0, cnt_rd},    32'(m_rd));
    check("cnt_wr",    {16'd0, cnt_wr},    32'(m_wr));
    check("range_err", {31'd0, range_err}, {31'd0, m_rerr});
    check("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
  endtask

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input bit instr,
                      input int nstall, input bit scramble);
    int  word;
    bit  inr;
    int  e0;
    last_ready_cyc = -1;
    last_rdata     = 32'hBAD0BAD0;
    @(negedge clk);
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = addr;
    bus_if.mem_wdata = wdata;
    bus_if.mem_wstrb = wstrb;
    bus_if.mem_instr = instr;
    word = int'(addr[31:2]);
    inr  = (addr[31:2] < 30'(MW));
    e0   = cyc + 1;
    last_e0  = e0;
    rdata_at = (wstrb == 4'd0 && inr) ? ram_m[word[7:0]] : 32'd0;
    ready_at = e0 + LAT + 1 + nstall;
    @(negedge clk);
    if (scramble) begin
      bus_if.mem_addr  = $urandom;
      bus_if.mem_wdata = $urandom;
      bus_if.mem_wstrb = 4'($urandom);
      bus_if.mem_instr = 1'($urandom);
    end
    if (nstall > 0) begin
      stall = 1'b1;
      repeat (nstall) @(negedge clk);
      stall = 1'b0;
    end
    while (cyc < ready_at) @(negedge clk);
    bus_if.mem_valid = 1'b0;
    if (wstrb != 4'd0 && inr)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ram_m[word[7:0]][8*b +: 8] = wdata[8*b +: 8];
    if (!inr) m_rerr = 1'b1;
    if (wstrb != 4'd0)      m_wr    = (m_wr == 65535) ? m_wr : m_wr + 1;
    else if (instr)         m_fetch = (m_fetch == 65535) ? m_fetch : m_fetch + 1;
    else                    m_rd    = (m_rd == 65535) ? m_rd : m_rd + 1;
    @(negedge clk);
    check_status();
  endtask

  task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    ready_at = -1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = addr;
    bus_if.mem_wdata = wdata;
    bus_if.mem_wstrb = 4'hF;
    bus_if.mem_instr = 1'b0;
    @(negedge clk);
    bus_if.mem_valid = 1'b0;
    @(negedge clk);
    m_perr = 1'b1;
    check_status();
  endtask

  task automatic reset_mid_wait(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    ready_at = -1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_addr  = addr;
    bus_if.mem_wdata = wdata;
    bus_if.mem_wstrb = 4'hF;
    bus_if.mem_instr = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus_if.mem_ready}, 32'd0);
    check("rst_rdata", bus_if.mem_rdata, 32'd0);
    check("rst_flags", {30'd0, range_err, proto_err}, 32'd0);
    check("rst_cnts",  {cnt_fetch, cnt_rd | cnt_wr}, 32'd0);
    m_fetch = 0; m_rd = 0; m_wr = 0; m_rerr = 0; m_perr = 0;
    bus_if.mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_status();
  endtask

  initial begin
    bus_if.mem_valid = 1'b0;
    bus_if.mem_instr = 1'b0;
    bus_if.mem_addr  = 32'd0;
    bus_if.mem_wdata = 32'd0;
    bus_if.mem_wstrb = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_flags", {30'd0, range_err, proto_err}, 32'd0);
    check("reset_cnts",  {cnt_fetch, cnt_rd | cnt_wr}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_status();

    // write then read back, base latency
    xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0);
    check("wr_latency", 32'(last_ready_cyc - last_e0), 32'd2);
    xfer(32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b1);
    check("rd_latency", 32'(last_ready_cyc - last_e0), 32'd2);
    check("rd_deadbeef", last_rdata, 32'hDEADBEEF);
    check("lit_cnt_wr", {16'd0, cnt_wr}, 32'd1);
    check("lit_cnt_rd", {16'd0, cnt_rd}, 32'd1);

    // byte-lane merge
    xfer(32'h20, 32'h11223344, 4'hF, 1'b0, 0, 1'b0);
    xfer(32'h20, 32'h0000AA00, 4'h2, 1'b0, 0, 1'b1);
    xfer(32'h20, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    check("byte_merge", last_rdata, 32'h1122AA44);

    // stall stretches the wait, fetch counter
    xfer(32'h10, 32'h0, 4'h0, 1'b0, 3, 1'b0);
    check("stall_latency", 32'(last_ready_cyc - last_e0), 32'd5);
    xfer(32'h10, 32'h0, 4'h0, 1'b1, 0, 1'b0);
    check("lit_cnt_fetch", {16'd0, cnt_fetch}, 32'd1);
    check("fetch_data", last_rdata, 32'hDEADBEEF);

    // out of range
    xfer(32'h0000_0400, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    check("oor_rdata", last_rdata, 32'd0);
    check("lit_range_err", {31'd0, range_err}, 32'd1);
    xfer(32'h0000_0404, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, 1'b0);
    xfer(32'h14, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    check("range_sticky", {31'd0, range_err}, 32'd1);

    // abort and reset mid-transfer
    abort_xfer(32'h10, 32'hFFFF_FFFF);
    check("lit_proto_err", {31'd0, proto_err}, 32'd1);
    check("abort_cnt_wr", {16'd0, cnt_wr}, 32'd4);
    reset_mid_wait(32'h20, 32'h0);
    xfer(32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    check("abort_no_write", last_rdata, 32'hDEADBEEF);
    xfer(32'h20, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    check("reset_no_write", last_rdata, 32'h1122AA44);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      int          sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        abort_xfer({24'd0, 3'd0, 3'($urandom), 2'd0}, $urandom);
      end else begin
        if (sel == 1) a = {20'($urandom_range(1, 4095)), 10'd0, 2'($urandom)} | 32'h400;
        else          a = {25'd0, 5'($urandom), 2'($urandom)};
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        xfer(a, $urandom, s, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
